// File: rtl/wb_uart_pkg.sv
// Shared definitions for wb_uart: register offsets, STATUS bit positions,
// serial FSM encodings and the divisor floor.
package wb_uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int STAT_RX_NONEMPTY = 0;
    localparam int STAT_TX_FULL     = 1;
    localparam int STAT_TX_IDLE     = 2;
    localparam int STAT_OVERRUN     = 3;
    localparam int STAT_FRAMING     = 4;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_BITS, TX_STOP} txState_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rxState_e;

    function automatic logic [15:0] effectiveDiv(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush, doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rdPtr_q];
    assign doPop   = pop_i & ~empty_o;
    assign doPush  = push_i & (~full_o | doPop);

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + 1'b1;
            end else if (!doPush && doPop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_uart.sv
// Wishbone-attached 8N1 UART: DATA/STATUS/DIV/CTRL registers, TX and RX FIFOs,
// sticky overrun/framing flags and a registered active-low interrupt.
module wb_uart
    import wb_uart_pkg::*;
#(
    parameter int DEFAULT_DIV = 434,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [29:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq_no
);

    logic        ack_q, irq_q, overrun_q, framing_q;
    logic [31:0] dat_q, readData;
    logic [15:0] div_q, effDiv;
    logic [1:0]  ctrl_q;
    logic [4:0]  status;
    logic        busReq, regWrite, txPush, rxPop;
    logic        txPop, txFull, txEmpty, txIdle;
    logic        rxPush, rxFull, rxEmpty, framingSet, overrunSet;
    logic [7:0]  txHead, rxHead;
    logic        unusedBits;

    txState_e    txState_q, txState_d;
    logic [15:0] txCnt_q, txCnt_d;
    logic [2:0]  txBit_q, txBit_d;
    logic [7:0]  txShift_q, txShift_d;
    logic        txLine_q, txLine_d;

    rxState_e    rxState_q, rxState_d;
    logic [15:0] rxCnt_q, rxCnt_d;
    logic [2:0]  rxBit_q, rxBit_d;
    logic [7:0]  rxShift_q, rxShift_d;
    logic        rxSync1_q, rxSync2_q, rxPrev_q;

    assign unusedBits = ^{wb_adr_i[29:2], wb_sel_i[3:2], wb_dat_i[31:16]};

    assign busReq     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign regWrite   = busReq & wb_we_i & wb_sel_i[0];
    assign txPush     = regWrite & (wb_adr_i[1:0] == ADDR_DATA);
    assign rxPop      = busReq & ~wb_we_i & (wb_adr_i[1:0] == ADDR_DATA) & ~rxEmpty;
    assign overrunSet = rxPush & rxFull & ~rxPop;
    assign txIdle     = txEmpty & (txState_q == TX_IDLE);
    assign effDiv     = effectiveDiv(div_q);

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign uart_tx  = txLine_q;
    assign irq_no   = irq_q;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txFifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (txPush),
        .pop_i   (txPop),
        .data_i  (wb_dat_i[7:0]),
        .data_o  (txHead),
        .full_o  (txFull),
        .empty_o (txEmpty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rxFifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rxPush),
        .pop_i   (rxPop),
        .data_i  (rxShift_q),
        .data_o  (rxHead),
        .full_o  (rxFull),
        .empty_o (rxEmpty)
    );

    assign status[STAT_RX_NONEMPTY] = ~rxEmpty;
    assign status[STAT_TX_FULL]     = txFull;
    assign status[STAT_TX_IDLE]     = txIdle;
    assign status[STAT_OVERRUN]     = overrun_q;
    assign status[STAT_FRAMING]     = framing_q;

    always_comb begin
        readData = '0;
        case (wb_adr_i[1:0])
            ADDR_DATA:   if (!rxEmpty) readData[7:0] = rxHead;
            ADDR_STATUS: readData[4:0] = status;
            ADDR_DIV:    readData[15:0] = div_q;
            ADDR_CTRL:   readData[1:0] = ctrl_q;
            default:     readData = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            div_q     <= 16'(DEFAULT_DIV);
            ctrl_q    <= '0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
            irq_q     <= 1'b1;
        end else begin
            ack_q <= busReq;
            dat_q <= (busReq && !wb_we_i) ? readData : '0;
            if (regWrite && wb_adr_i[1:0] == ADDR_DIV) begin
                div_q[7:0] <= wb_dat_i[7:0];
                if (wb_sel_i[1]) begin
                    div_q[15:8] <= wb_dat_i[15:8];
                end
            end
            if (regWrite && wb_adr_i[1:0] == ADDR_CTRL) begin
                ctrl_q <= wb_dat_i[1:0];
            end
            // A new error event wins over a simultaneous write-1-clear.
            if (overrunSet) begin
                overrun_q <= 1'b1;
            end else if (regWrite && wb_adr_i[1:0] == ADDR_STATUS && wb_dat_i[STAT_OVERRUN]) begin
                overrun_q <= 1'b0;
            end
            if (framingSet) begin
                framing_q <= 1'b1;
            end else if (regWrite && wb_adr_i[1:0] == ADDR_STATUS && wb_dat_i[STAT_FRAMING]) begin
                framing_q <= 1'b0;
            end
            irq_q <= ~((ctrl_q[0] & ~rxEmpty) | (ctrl_q[1] & txIdle));
        end
    end

    // Bit counters reload from the current divisor at every bit boundary,
    // so a DIV write during a frame applies from the next bit.
    always_comb begin
        txState_d = txState_q;
        txCnt_d   = txCnt_q;
        txBit_d   = txBit_q;
        txShift_d = txShift_q;
        txPop     = 1'b0;
        if (txState_q != TX_IDLE && txCnt_q != '0) begin
            txCnt_d = txCnt_q - 16'd1;
        end else begin
            case (txState_q)
                TX_IDLE, TX_STOP: begin
                    txState_d = TX_IDLE;
                    if (!txEmpty) begin
                        txPop     = 1'b1;
                        txShift_d = txHead;
                        txState_d = TX_START;
                        txCnt_d   = effDiv - 16'd1;
                    end
                end
                TX_START: begin
                    txState_d = TX_BITS;
                    txBit_d   = 3'd0;
                    txCnt_d   = effDiv - 16'd1;
                end
                TX_BITS: begin
                    txCnt_d = effDiv - 16'd1;
                    if (txBit_q == 3'd7) begin
                        txState_d = TX_STOP;
                    end else begin
                        txShift_d = txShift_q >> 1;
                        txBit_d   = txBit_q + 3'd1;
                    end
                end
                default: txState_d = TX_IDLE;
            endcase
        end
        txLine_d = (txState_d == TX_START) ? 1'b0 :
                   (txState_d == TX_BITS)  ? txShift_d[0] : 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            txState_q <= TX_IDLE;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txShift_q <= '0;
            txLine_q  <= 1'b1;
        end else begin
            txState_q <= txState_d;
            txCnt_q   <= txCnt_d;
            txBit_q   <= txBit_d;
            txShift_q <= txShift_d;
            txLine_q  <= txLine_d;
        end
    end

    // The START wait is half a bit so every later sample lands mid-bit.
    always_comb begin
        rxState_d  = rxState_q;
        rxCnt_d    = rxCnt_q;
        rxBit_d    = rxBit_q;
        rxShift_d  = rxShift_q;
        rxPush     = 1'b0;
        framingSet = 1'b0;
        if (rxState_q != RX_IDLE && rxCnt_q != '0) begin
            rxCnt_d = rxCnt_q - 16'd1;
        end else begin
            case (rxState_q)
                RX_IDLE: begin
                    if (rxPrev_q && !rxSync2_q) begin
                        rxState_d = RX_START;
                        rxCnt_d   = (effDiv >> 1) - 16'd1;
                    end
                end
                RX_START: begin
                    if (rxSync2_q) begin
                        rxState_d = RX_IDLE;
                    end else begin
                        rxState_d = RX_BITS;
                        rxBit_d   = 3'd0;
                        rxCnt_d   = effDiv - 16'd1;
                    end
                end
                RX_BITS: begin
                    rxShift_d = {rxSync2_q, rxShift_q[7:1]};
                    rxCnt_d   = effDiv - 16'd1;
                    if (rxBit_q == 3'd7) begin
                        rxState_d = RX_STOP;
                    end else begin
                        rxBit_d = rxBit_q + 3'd1;
                    end
                end
                RX_STOP: begin
                    rxState_d  = RX_IDLE;
                    rxPush     = rxSync2_q;
                    framingSet = ~rxSync2_q;
                end
                default: rxState_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxState_q <= RX_IDLE;
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxShift_q <= '0;
            rxSync1_q <= 1'b1;
            rxSync2_q <= 1'b1;
            rxPrev_q  <= 1'b1;
        end else begin
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxBit_q   <= rxBit_d;
            rxShift_q <= rxShift_d;
            rxSync1_q <= uart_rx;
            rxSync2_q <= rxSync1_q;
            rxPrev_q  <= rxSync2_q;
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// Directed self-checking bench for wb_uart: register access, TX framing,
// RX reception, error flags, interrupt and reset behaviour.
module tb_wb_uart;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        wbCyc = 1'b0, wbStb = 1'b0, wbWe = 1'b0;
    logic [3:0]  wbSel = '0;
    logic [29:0] wbAdr = '0;
    logic [31:0] wbDat = '0;
    logic [31:0] wbDatO;
    logic        wbAck;
    logic        uartRx = 1'b1;
    logic        uartTx;
    logic        irqN;

    int compared = 0;
    int mismatched = 0;

    wb_uart dut (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .wb_cyc_i (wbCyc),
        .wb_stb_i (wbStb),
        .wb_we_i  (wbWe),
        .wb_sel_i (wbSel),
        .wb_adr_i (wbAdr),
        .wb_dat_i (wbDat),
        .wb_dat_o (wbDatO),
        .wb_ack_o (wbAck),
        .uart_rx  (uartRx),
        .uart_tx  (uartTx),
        .irq_no   (irqN)
    );

    always #5 clk = ~clk;

    task automatic wbXfer(input logic we, input logic [1:0] adr, input logic [31:0] wdat,
                          input logic [3:0] sel, output logic [31:0] rdat);
        bit got;
        got  = 1'b0;
        rdat = '0;
        @(negedge clk);
        wbCyc = 1'b1; wbStb = 1'b1; wbWe = we;
        wbAdr = {28'd0, adr}; wbDat = wdat; wbSel = sel;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (wbAck) begin
                got  = 1'b1;
                rdat = wbDatO;
            end
        end
        wbCyc = 1'b0; wbStb = 1'b0; wbWe = 1'b0;
        if (!got) begin
            compared++; mismatched++;
            $display("[TB] FAIL wb_ack_timeout: got no ack, required ack within 8 cycles");
        end
    endtask

    task automatic wbWrite(input logic [1:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
        logic [31:0] dummy;
        wbXfer(1'b1, adr, wdat, sel, dummy);
    endtask

    task automatic wbRead(input logic [1:0] adr, output logic [31:0] rdat);
        wbXfer(1'b0, adr, 32'h0, 4'b1111, rdat);
    endtask

    task automatic driveFrame(input logic [7:0] b, input logic stopBit);
        logic [9:0] bits;
        bits = {stopBit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uartRx = bits[i];
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        uartRx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rstN = 1'b1;
        #1 rstN = 1'b0;
        #1;
        compared++; if (uartTx !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_uart_tx: got %b, required 1", uartTx); end
        compared++; if (irqN !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_irq_no: got %b, required 1", irqN); end
        compared++; if (wbAck !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_ack: got %b, required 0", wbAck); end
        compared++; if (wbDatO !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_dat_o: got 0x%08h, required 0x00000000", wbDatO); end
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        wbRead(2'd1, d);
        compared++; if (d !== 32'h4) begin mismatched++; $display("[TB] FAIL rst_status: got 0x%08h, required 0x00000004", d); end
        wbRead(2'd2, d);
        compared++; if (d !== 32'd434) begin mismatched++; $display("[TB] FAIL rst_div: got 0x%08h, required 0x000001b2", d); end
        wbRead(2'd3, d);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_ctrl: got 0x%08h, required 0x00000000", d); end
    endtask

    task automatic test_registers();
        logic [31:0] d;
        wbWrite(2'd2, 32'h0000_1234, 4'b0001);
        wbRead(2'd2, d);
        compared++; if (d !== 32'h0134) begin mismatched++; $display("[TB] FAIL div_low_lane: got 0x%08h, required 0x00000134", d); end
        wbWrite(2'd2, 32'hFFFF_0008, 4'b0011);
        wbRead(2'd2, d);
        compared++; if (d !== 32'h0008) begin mismatched++; $display("[TB] FAIL div_two_lanes: got 0x%08h, required 0x00000008", d); end
        wbWrite(2'd3, 32'h0000_0003, 4'b0010);
        wbRead(2'd3, d);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL ctrl_no_lane0: got 0x%08h, required 0x00000000", d); end
    endtask

    task automatic test_tx();
        logic [31:0] d;
        logic [9:0]  frame;
        logic [7:0]  byteV;
        logic [15:0] divV;
        bit          found;
        for (int f = 0; f < 2; f++) begin
            divV  = (f == 0) ? 16'd4 : 16'd2;
            byteV = (f == 0) ? 8'hA5 : 8'h3C;
            frame = {1'b1, byteV, 1'b0};
            wbWrite(2'd2, {16'd0, divV}, 4'b0011);
            wbWrite(2'd0, {24'd0, byteV}, 4'b0001);
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (uartTx === 1'b0) found = 1'b1;
            end
            compared++; if (!found) begin mismatched++; $display("[TB] FAIL tx_start_seen: got no start bit, required start within 20 cycles"); end
            for (int k = 0; k < 40; k++) begin
                if (k > 0) @(negedge clk);
                compared++;
                if (uartTx !== frame[k/4]) begin
                    mismatched++;
                    $display("[TB] FAIL tx_bit frame %0d cycle %0d: got %b, required %b", f, k, uartTx, frame[k/4]);
                end
            end
            repeat (4) @(negedge clk);
            wbRead(2'd1, d);
            compared++; if (d !== 32'h4) begin mismatched++; $display("[TB] FAIL tx_idle_after: got 0x%08h, required 0x00000004", d); end
        end
    endtask

    task automatic test_rx();
        logic [31:0] d;
        wbWrite(2'd2, 32'd8, 4'b0011);
        driveFrame(8'h3C, 1'b1);
        wbRead(2'd1, d);
        compared++; if (d !== 32'h5) begin mismatched++; $display("[TB] FAIL rx_status_pending: got 0x%08h, required 0x00000005", d); end
        wbRead(2'd0, d);
        compared++; if (d !== 32'h3C) begin mismatched++; $display("[TB] FAIL rx_data_3c: got 0x%08h, required 0x0000003c", d); end
        wbRead(2'd1, d);
        compared++; if (d !== 32'h4) begin mismatched++; $display("[TB] FAIL rx_status_drained: got 0x%08h, required 0x00000004", d); end
        driveFrame(8'h81, 1'b1);
        driveFrame(8'hC3, 1'b1);
        wbRead(2'd0, d);
        compared++; if (d !== 32'h81) begin mismatched++; $display("[TB] FAIL rx_data_81: got 0x%08h, required 0x00000081", d); end
        wbRead(2'd0, d);
        compared++; if (d !== 32'hC3) begin mismatched++; $display("[TB] FAIL rx_data_c3: got 0x%08h, required 0x000000c3", d); end
        wbRead(2'd0, d);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL rx_read_empty: got 0x%08h, required 0x00000000", d); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        for (int i = 0; i < 17; i++) begin
            driveFrame(8'h40 + 8'(i), 1'b1);
        end
        wbRead(2'd1, d);
        compared++; if (d !== 32'h0D) begin mismatched++; $display("[TB] FAIL ovr_status_set: got 0x%08h, required 0x0000000d", d); end
        for (int i = 0; i < 16; i++) begin
            wbRead(2'd0, d);
            compared++;
            if (d !== 32'h40 + 32'(i)) begin
                mismatched++;
                $display("[TB] FAIL ovr_data %0d: got 0x%08h, required 0x%08h", i, d, 32'h40 + 32'(i));
            end
        end
        wbRead(2'd1, d);
        compared++; if (d !== 32'h0C) begin mismatched++; $display("[TB] FAIL ovr_status_empty: got 0x%08h, required 0x0000000c", d); end
        wbWrite(2'd1, 32'h08, 4'b0001);
        wbRead(2'd1, d);
        compared++; if (d !== 32'h04) begin mismatched++; $display("[TB] FAIL ovr_clear: got 0x%08h, required 0x00000004", d); end
    endtask

    task automatic test_framing_glitch();
        logic [31:0] d;
        driveFrame(8'h55, 1'b0);
        wbRead(2'd1, d);
        compared++; if (d !== 32'h14) begin mismatched++; $display("[TB] FAIL frm_status_set: got 0x%08h, required 0x00000014", d); end
        wbRead(2'd0, d);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL frm_no_push: got 0x%08h, required 0x00000000", d); end
        wbWrite(2'd1, 32'h10, 4'b0001);
        wbRead(2'd1, d);
        compared++; if (d !== 32'h04) begin mismatched++; $display("[TB] FAIL frm_clear: got 0x%08h, required 0x00000004", d); end
        @(negedge clk);
        uartRx = 1'b0;
        @(negedge clk);
        uartRx = 1'b1;
        repeat (30) @(negedge clk);
        wbRead(2'd1, d);
        compared++; if (d !== 32'h04) begin mismatched++; $display("[TB] FAIL glitch_ignored: got 0x%08h, required 0x00000004", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        driveFrame(8'h5A, 1'b1);
        @(negedge clk);
        compared++; if (irqN !== 1'b1) begin mismatched++; $display("[TB] FAIL irq_disabled: got %b, required 1", irqN); end
        wbWrite(2'd3, 32'h1, 4'b0001);
        @(negedge clk);
        compared++; if (irqN !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_rx_pending: got %b, required 0", irqN); end
        wbRead(2'd0, d);
        compared++; if (d !== 32'h5A) begin mismatched++; $display("[TB] FAIL irq_pop_data: got 0x%08h, required 0x0000005a", d); end
        @(negedge clk);
        compared++; if (irqN !== 1'b1) begin mismatched++; $display("[TB] FAIL irq_after_pop: got %b, required 1", irqN); end
        wbWrite(2'd3, 32'h2, 4'b0001);
        @(negedge clk);
        compared++; if (irqN !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_tx_idle: got %b, required 0", irqN); end
        wbWrite(2'd3, 32'h0, 4'b0001);
        @(negedge clk);
        compared++; if (irqN !== 1'b1) begin mismatched++; $display("[TB] FAIL irq_cleared: got %b, required 1", irqN); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int          acks;
        wbWrite(2'd2, 32'd1000, 4'b0011);
        @(negedge clk);
        wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b1;
        wbAdr = 30'd0; wbDat = 32'h11; wbSel = 4'b0001;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wbAck) acks++;
        end
        wbCyc = 1'b0; wbStb = 1'b0; wbWe = 1'b0;
        compared++; if (acks != 3) begin mismatched++; $display("[TB] FAIL b2b_ack_count: got %0d, required 3", acks); end
        wbWrite(2'd0, 32'h22, 4'b1000);
        for (int i = 0; i < 13; i++) begin
            wbWrite(2'd0, 32'(i), 4'b0001);
        end
        wbRead(2'd1, d);
        compared++; if (d !== 32'h00) begin mismatched++; $display("[TB] FAIL b2b_not_full: got 0x%08h, required 0x00000000", d); end
        wbWrite(2'd0, 32'h33, 4'b0001);
        wbRead(2'd1, d);
        compared++; if (d !== 32'h02) begin mismatched++; $display("[TB] FAIL b2b_full: got 0x%08h, required 0x00000002", d); end
        wbWrite(2'd0, 32'h44, 4'b0001);
        wbRead(2'd1, d);
        compared++; if (d !== 32'h02) begin mismatched++; $display("[TB] FAIL b2b_write_full: got 0x%08h, required 0x00000002", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        bit          sawLow;
        compared++; if (uartTx !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_tx_busy: got %b, required 0", uartTx); end
        #2 rstN = 1'b0;
        #1;
        compared++; if (uartTx !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_rst_tx: got %b, required 1", uartTx); end
        compared++; if (wbAck !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_ack: got %b, required 0", wbAck); end
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        wbRead(2'd1, d);
        compared++; if (d !== 32'h04) begin mismatched++; $display("[TB] FAIL mid_status: got 0x%08h, required 0x00000004", d); end
        wbRead(2'd2, d);
        compared++; if (d !== 32'd434) begin mismatched++; $display("[TB] FAIL mid_div: got 0x%08h, required 0x000001b2", d); end
        sawLow = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (uartTx !== 1'b1) sawLow = 1'b1;
        end
        compared++; if (sawLow) begin mismatched++; $display("[TB] FAIL mid_no_resume: got tx activity, required idle line"); end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_tx();
        test_rx();
        test_overrun();
        test_framing_glitch();
        test_irq();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, required finish within 50000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
